sap_fetch_seq: RTL and testbench
================================

# sap_fetch_seq

Instruction fetch/execute sequencer for the SAP datapath. It holds the program counter, the memory address register and the instruction register, and runs a six-state ring counter. It drives the 16x8 program/data ROM's `address` and active-low `CE_`, and captures the ROM's output into the instruction register (IR) or the data register. Downstream accumulator/ALU logic consumes `opcode`, `data_reg`, `data_valid` and `out_strobe`.

## Interface
- `ADDR_W`, 4: PC/MAR width; the ROM depth is 2^ADDR_W.
- `DATA_W`, 8: ROM word width; the upper 4 bits are the opcode, the lower ADDR_W bits are the operand.
- `HLT_OPCODE`, 4'hF: opcode that halts the sequencer.
- `OUT_OPCODE`, 4'hE: opcode that pulses `out_strobe`.
- `CLK`  in  1  system clock, rising edge.
- `CLR_`  in  1  reset, asynchronous and active-low.
- `ROM_Out`  in  DATA_W  ROM read data; only valid while `CE_`=0.
- `address`  out  ADDR_W  MAR contents, wired to the ROM address.
- `CE_`  out  1  ROM chip enable, active-low.
- `opcode`  out  4  IR[7:4].
- `operand`  out  ADDR_W  IR[3:0].
- `T_state`  out  6  one-hot ring state T1..T6; all zero when halted.
- `data_reg`  out  DATA_W  last operand word read from the ROM.
- `data_valid`  out  1  one-cycle pulse in T6 of a memory-reference instruction.
- `out_strobe`  out  1  one-cycle pulse in T4 of an OUT instruction.
- `HLT`  out  1  sticky halt flag.
- `STEP`  in  1  advance enable; present only with `SAP_STEP_EN`.

## Operation
- Memory-reference opcodes are 0x0 (LDA), 0x1 (ADD) and 0x2 (SUB). Any other opcode except OUT and HLT is a no-op.
- Ring sequence: T1→T2→T3→T4→T5→T6→T1.
  - T1: MAR ← PC.
  - T2: PC ← PC+1, modulo 2^ADDR_W (0xF wraps to 0x0).
  - T3: `CE_`=0; IR ← ROM_Out on the closing edge.
  - T4:
    - Memory-reference opcode: MAR ← operand.
    - OUT_OPCODE: `out_strobe`=1.
    - HLT_OPCODE: HLT ← 1 on the closing edge.
  - T5: for a memory-reference opcode, `CE_`=0 and data_reg ← ROM_Out on the closing edge. Otherwise idle with `CE_`=1.
  - T6: `data_valid`=1 only for a memory-reference opcode. Otherwise idle.
- Halt: after HLT is set, `T_state`=0. PC, MAR, IR and data_reg are frozen, and `CE_`=1. Only `CLR_` exits the halt.
- `CE_`, `out_strobe` and `data_valid` are decoded only from registered state (`T_state` and IR). There is no combinational path from any input.
- The IR captures whatever the ROM drives in T3, including X or Z. This block does not check operand validity.
- Reset values, applied asynchronously on `CLR_`=0:
  - PC=0, MAR=0, so `address`=0.
  - IR=0x00, data_reg=0x00.
  - `T_state`=6'b000001 (T1).
  - `CE_`=1, `HLT`=0, `data_valid`=0, `out_strobe`=0.
- Reset mid-instruction, in any state, aborts immediately to the reset values. No partial update survives.

## Timing
- Fetch latency is 3 cycles: the IR is valid from the first cycle of T4.
- Each instruction takes exactly 6 cycles. Consecutive instructions have no gap.
- `address` changes only on the edges closing T1 and T4.
- `CE_` is low for exactly one cycle per fetch, plus one cycle (T5) per memory-reference instruction.
- data_reg is stable from T6 until the T5 of the next memory-reference instruction.
- `CLR_` deassertion is assumed synchronous to CLK by the system. The first rising edge after deassertion executes T1.

## Configuration
- `SAP_STEP_EN` defined:
  - The `STEP` port exists.
  - All state updates (ring, PC, MAR, IR, data_reg, HLT) occur only on edges where `STEP`=1. With `STEP`=0 everything holds, including the current `CE_` and strobe levels.
  - `data_valid` and `out_strobe` remain one-state-long, so they can last several cycles while stepping is paused.
- `SAP_STEP_EN` undefined: no `STEP` port, and the ring advances on every clock edge.

## Test plan
- Reset: hold `CLR_`=0 for 3 cycles, then check `address`=0, `CE_`=1, `T_state`=000001, `HLT`=0, `data_valid`=0 and `out_strobe`=0. Pulse `CLR_` low mid-T3 and check the asynchronous return to the same values before the next edge.
- LDA: ROM[0]=0x09, ROM[9]=0x10.
  - `CE_`=0 in cycles 3 and 5.
  - `address`=0 in T1–T4, then 9 from T5.
  - IR=0x09 in T4.
  - `data_valid`=1 in cycle 6 with `data_reg`=0x10.
  - PC=1 after T2.
- Program 09,1A,1B,2C,E0,F0:
  - `data_valid` pulses with 0x10, 0x14, 0x18, 0x20.
  - `out_strobe` is high in cycle 28 (instruction 5, T4).
  - `HLT`=1 after cycle 34 (instruction 6, T4 edge); thereafter `T_state`=0 and `CE_`=1 for 20 idle cycles.
- PC wrap: fill the ROM with 0x30 (no-op). After 16 instructions, the T1 of the 17th loads `address`=0. `data_valid` never asserts.
- Reset mid-T5 of an ADD: the sequence restarts at `address`=0, and `data_reg` reads 0x00 (not the partial value).
- `SAP_STEP_EN`: hold `STEP`=0 for 5 cycles inside T3 and check that `CE_` stays 0 and the IR is unchanged. Pulse `STEP` once and check `T_state`=T4.

Source files
------------

// File: rtl/sap_fetch_seq.sv
// sap_fetch_seq: SAP fetch/execute sequencer.
// Holds PC, MAR, IR and data_reg, and runs a six-state one-hot ring T1..T6.
// Optional single-step gating is enabled with `define SAP_STEP_EN (adds STEP).
module sap_fetch_seq #(
  parameter int         ADDR_W     = 4,
  parameter int         DATA_W     = 8,
  parameter logic [3:0] HLT_OPCODE = 4'hF,
  parameter logic [3:0] OUT_OPCODE = 4'hE
) (
  input  logic              CLK,
  input  logic              CLR_,
`ifdef SAP_STEP_EN
  input  logic              STEP,
`endif
  input  logic [DATA_W-1:0] ROM_Out,
  output logic [ADDR_W-1:0] address,
  output logic              CE_,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [5:0]        T_state,
  output logic [DATA_W-1:0] data_reg,
  output logic              data_valid,
  output logic              out_strobe,
  output logic              HLT
);

  // One-hot ring; all-zero encoding doubles as the halted state.
  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] ir;
  logic              adv;
  logic              memref;

`ifdef SAP_STEP_EN
  assign adv = STEP;
`else
  assign adv = 1'b1;
`endif

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];
  // LDA, ADD, SUB read a second ROM word in T5.
  assign memref  = (opcode == 4'h0) || (opcode == 4'h1) || (opcode == 4'h2);

  // Ring state register; reset aborts straight back to T1.
  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_)    state <= S_T1;
    else if (adv) state <= state_nx;
  end

  // Ring advance; HLT in T4 drops into the all-zero halted state for good.
  always_comb begin
    state_nx = state;
    case (state)
      S_T1:    state_nx = S_T2;
      S_T2:    state_nx = S_T3;
      S_T3:    state_nx = S_T4;
      S_T4:    state_nx = (opcode == HLT_OPCODE) ? S_HALT : S_T5;
      S_T5:    state_nx = S_T6;
      S_T6:    state_nx = S_T1;
      default: state_nx = S_HALT;
    endcase
  end

  // Datapath registers, each updated on the edge that closes its T-state.
  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      pc       <= '0;
      mar      <= '0;
      ir       <= '0;
      data_reg <= '0;
    end else if (adv) begin
      case (state)
        S_T1:    mar <= pc;
        S_T2:    pc  <= pc + ADDR_W'(1);
        S_T3:    ir  <= ROM_Out;
        S_T4:    if (memref) mar <= operand;
        S_T5:    if (memref) data_reg <= ROM_Out;
        default: ;
      endcase
    end
  end

  // Strobes decode from registered state only, never from inputs.
  always_comb begin
    address    = mar;
    T_state    = state;
    HLT        = (state == S_HALT);
    CE_        = !((state == S_T3) || ((state == S_T5) && memref));
    out_strobe = (state == S_T4) && (opcode == OUT_OPCODE);
    data_valid = (state == S_T6) && memref;
  end

endmodule

// File: tb/tb_sap_fetch_seq.sv
// tb_sap_fetch_seq: directed vectors against hand-derived cycle timings.
module tb_sap_fetch_seq;
  logic       CLK, CLR_;
  logic       STEP;
  logic [7:0] ROM_Out;
  logic [3:0] address, operand, opcode;
  logic       CE_, data_valid, out_strobe, HLT;
  logic [5:0] T_state;
  logic [7:0] data_reg;
  logic [7:0] rom [16];

  int nvec = 0;
  int nerr = 0;

  sap_fetch_seq dut (
    .CLK(CLK), .CLR_(CLR_),
`ifdef SAP_STEP_EN
    .STEP(STEP),
`endif
    .ROM_Out(ROM_Out), .address(address), .CE_(CE_), .opcode(opcode),
    .operand(operand), .T_state(T_state), .data_reg(data_reg),
    .data_valid(data_valid), .out_strobe(out_strobe), .HLT(HLT)
  );

  // ROM reads back 0xFF while disabled so a mistimed capture looks like HLT.
  assign ROM_Out = CE_ ? 8'hFF : rom[address];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Leaves the bench in cycle 1 (T1) of a fresh run.
  task automatic do_reset();
    CLR_ = 1'b0;
    repeat (3) tick();
    CLR_ = 1'b1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    CLR_ = 1'b0;
    STEP = 1'b1;
    fill(8'h30);

    // Reset values
    do_reset();
    chk("rst addr", 32'(address), 32'h0);
    chk("rst ce", 32'(CE_), 32'h1);
    chk("rst t", 32'(T_state), 32'h01);
    chk("rst hlt", 32'(HLT), 32'h0);
    chk("rst dv", 32'(data_valid), 32'h0);
    chk("rst os", 32'(out_strobe), 32'h0);

    // Asynchronous reset pulse in the middle of T3
    tick(); tick();
    chk("t3 ce", 32'(CE_), 32'h0);
    #2 CLR_ = 1'b0;
    #1;
    chk("arst t", 32'(T_state), 32'h01);
    chk("arst ce", 32'(CE_), 32'h1);
    chk("arst addr", 32'(address), 32'h0);
    tick();
    CLR_ = 1'b1;

    // Single LDA
    fill(8'h30);
    rom[0] = 8'h09; rom[9] = 8'h10;
    do_reset();
    chk("lda c1 addr", 32'(address), 32'h0);
    tick();
    chk("lda c2 t", 32'(T_state), 32'h02);
    chk("lda c2 ce", 32'(CE_), 32'h1);
    tick();
    chk("lda c3 ce", 32'(CE_), 32'h0);
    chk("lda c3 addr", 32'(address), 32'h0);
    tick();
    chk("lda c4 ir", 32'({opcode, operand}), 32'h09);
    chk("lda c4 addr", 32'(address), 32'h0);
    chk("lda c4 ce", 32'(CE_), 32'h1);
    tick();
    chk("lda c5 addr", 32'(address), 32'h9);
    chk("lda c5 ce", 32'(CE_), 32'h0);
    tick();
    chk("lda c6 dv", 32'(data_valid), 32'h1);
    chk("lda c6 dreg", 32'(data_reg), 32'h10);
    tick();
    chk("lda c7 dv", 32'(data_valid), 32'h0);
    chk("lda c7 addr", 32'(address), 32'h9);
    tick();
    chk("lda c8 addr pc", 32'(address), 32'h1);

    // Program 09,1A,1B,2C,E0,F0 checked cycle by cycle
    fill(8'h30);
    rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'h1B; rom[3] = 8'h2C;
    rom[4] = 8'hE0; rom[5] = 8'hF0;
    rom[9] = 8'h10; rom[10] = 8'h14; rom[11] = 8'h18; rom[12] = 8'h20;
    do_reset();
    for (int c = 1; c <= 54; c++) begin
      logic       e_dv, e_os, e_hlt, e_ce;
      logic [5:0] e_t;
      logic [7:0] e_d;
      e_dv  = (c == 6) || (c == 12) || (c == 18) || (c == 24);
      e_os  = (c == 28);
      e_hlt = (c >= 35);
      e_ce  = !(c == 3 || c == 5 || c == 9 || c == 11 || c == 15 || c == 17 ||
                c == 21 || c == 23 || c == 27 || c == 33);
      e_t   = e_hlt ? 6'h00 : 6'(1 << ((c - 1) % 6));
      e_d   = (c == 6) ? 8'h10 : (c == 12) ? 8'h14 : (c == 18) ? 8'h18 : 8'h20;
      chk($sformatf("prg c%0d t", c), 32'(T_state), 32'(e_t));
      chk($sformatf("prg c%0d ce", c), 32'(CE_), 32'(e_ce));
      chk($sformatf("prg c%0d dv", c), 32'(data_valid), 32'(e_dv));
      chk($sformatf("prg c%0d os", c), 32'(out_strobe), 32'(e_os));
      chk($sformatf("prg c%0d hlt", c), 32'(HLT), 32'(e_hlt));
      if (e_dv) chk($sformatf("prg c%0d dreg", c), 32'(data_reg), 32'(e_d));
      tick();
    end

    // PC wrap across 16 no-ops
    fill(8'h30);
    do_reset();
    begin
      logic dv_seen;
      dv_seen = 1'b0;
      for (int c = 1; c <= 97; c++) begin
        if (data_valid) dv_seen = 1'b1;
        if (c == 92) chk("wrap c92 addr", 32'(address), 32'hF);
        if (c == 97) chk("wrap c97 addr", 32'(address), 32'hF);
        tick();
      end
      chk("wrap c98 addr", 32'(address), 32'h0);
      chk("wrap no dv", 32'(dv_seen), 32'h0);
    end

    // Reset during T5 of an ADD
    fill(8'h30);
    rom[0] = 8'h09; rom[1] = 8'h1A; rom[9] = 8'h10; rom[10] = 8'h14;
    do_reset();
    repeat (10) tick();
    chk("add c11 t", 32'(T_state), 32'h10);
    chk("add c11 dreg", 32'(data_reg), 32'h10);
    #2 CLR_ = 1'b0;
    #1;
    chk("add arst dreg", 32'(data_reg), 32'h00);
    chk("add arst t", 32'(T_state), 32'h01);
    chk("add arst addr", 32'(address), 32'h0);
    tick();
    CLR_ = 1'b1;
    chk("add rel dreg", 32'(data_reg), 32'h00);
    repeat (5) tick();
    chk("add re c6 dv", 32'(data_valid), 32'h1);
    chk("add re c6 dreg", 32'(data_reg), 32'h10);

`ifdef SAP_STEP_EN
    // Stepping paused inside T3
    fill(8'h30);
    rom[0] = 8'h09;
    do_reset();
    tick(); tick();
    STEP = 1'b0;
    repeat (5) tick();
    chk("step hold t", 32'(T_state), 32'h04);
    chk("step hold ce", 32'(CE_), 32'h0);
    chk("step hold ir", 32'({opcode, operand}), 32'h00);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    chk("step t4", 32'(T_state), 32'h08);
    chk("step ir", 32'({opcode, operand}), 32'h09);
    STEP = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
